pc_sequencer: RTL and testbench

- Registered, parametrised program counter for the philv core. It replaces the pass-through PC with a clocked sequencer.
- Each cycle it selects the next fetch address from: sequential increment, branch, jump, trap entry, trap return or hold.
- It keeps an exception PC, handles misaligned redirect targets, and runs a small boot/run/halt state machine.
- It sits between the decode/execute redirect logic and the instruction memory address port.

---
 rtl/pc_sequencer.sv | 113 +++++++++++
 tb/tb_pc_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Registered program counter for the philv core: picks the next fetch address,
// keeps the exception PC and cause, and runs a BOOT/RUN/HALT state machine.
module pc_sequencer #(
    parameter int unsigned     N            = 32,
    parameter logic [N-1:0]    RESET_VECTOR = '0,
    parameter logic [N-1:0]    TRAP_VECTOR  = N'(32'h0000_0100),
    parameter int unsigned     INSTR_BYTES  = 4,
    parameter int unsigned     ALIGN_BITS   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         halt,
    input  logic         resume,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    input  logic         jump,
    input  logic [N-1:0] jump_target,
    input  logic         trap,
    input  logic         mret,
    output logic [N-1:0] pc,
    output logic [N-1:0] pc_next_seq,
    output logic [N-1:0] epc,
    output logic [1:0]   trap_cause,
    output logic         fetch_valid,
    output logic         halted
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [1:0] CAUSE_NONE     = 2'd0;
    localparam logic [1:0] CAUSE_EXTERNAL = 2'd1;
    localparam logic [1:0] CAUSE_MISALIGN = 2'd2;

    logic [1:0]   r_state;
    logic [N-1:0] r_pc;
    logic [N-1:0] r_epc;
    logic [1:0]   r_cause;

    logic [N-1:0] w_pc_inc;
    logic [N-1:0] w_target;
    logic         w_redirect;
    logic         w_misaligned;

    // Jump outranks branch, so the jump target is the one checked for alignment.
    always_comb begin
        w_pc_inc     = r_pc + N'(INSTR_BYTES);
        w_redirect   = jump | branch_taken;
        w_target     = jump ? jump_target : branch_target;
        w_misaligned = w_redirect && (w_target[ALIGN_BITS-1:0] != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_VECTOR;
            r_epc   <= '0;
            r_cause <= CAUSE_NONE;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (trap) begin
                        r_epc   <= r_pc;
                        r_cause <= CAUSE_EXTERNAL;
                        r_pc    <= TRAP_VECTOR;
                    end else if (stall) begin
                        r_pc <= r_pc;
                    end else if (halt) begin
                        r_state <= ST_HALT;
                    end else if (mret) begin
                        r_pc    <= r_epc;
                        r_cause <= CAUSE_NONE;
                    end else if (w_misaligned) begin
                        r_epc   <= r_pc;
                        r_cause <= CAUSE_MISALIGN;
                        r_pc    <= TRAP_VECTOR;
                    end else if (w_redirect) begin
                        r_pc <= w_target;
                    end else begin
                        r_pc <= w_pc_inc;
                    end
                end
                ST_HALT: begin
                    if (trap) begin
                        r_epc   <= r_pc;
                        r_cause <= CAUSE_EXTERNAL;
                        r_pc    <= TRAP_VECTOR;
                        r_state <= ST_RUN;
                    end else if (resume) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_BOOT;
                    r_pc    <= RESET_VECTOR;
                end
            endcase
        end
    end

    assign pc          = r_pc;
    assign pc_next_seq = w_pc_inc;
    assign epc         = r_epc;
    assign trap_cause  = r_cause;
    assign fetch_valid = (r_state == ST_RUN);
    assign halted      = (r_state == ST_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: hand-computed expectations checked with
// immediate assertions after each rising edge.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        halt;
    logic        resume;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        trap;
    logic        mret;
    logic [31:0] pc;
    logic [31:0] pc_next_seq;
    logic [31:0] epc;
    logic [1:0]  trap_cause;
    logic        fetch_valid;
    logic        halted;

    int checks = 0;
    int errors = 0;

    pc_sequencer #(
        .N            (32),
        .RESET_VECTOR (32'h0000_0000),
        .TRAP_VECTOR  (32'h0000_0100),
        .INSTR_BYTES  (4),
        .ALIGN_BITS   (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .halt          (halt),
        .resume        (resume),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .trap          (trap),
        .mret          (mret),
        .pc            (pc),
        .pc_next_seq   (pc_next_seq),
        .epc           (epc),
        .trap_cause    (trap_cause),
        .fetch_valid   (fetch_valid),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; halt = 0; resume = 0; branch_taken = 0; branch_target = '0;
        jump = 0; jump_target = '0; trap = 0; mret = 0;
    endtask

    initial begin
        rst_n = 0;
        clear_inputs();
        #2;
        chk("reset_pc", pc, 32'h0);
        chk("reset_fv", {31'b0, fetch_valid}, 32'h0);
        chk("reset_halted", {31'b0, halted}, 32'h0);
        chk("reset_epc", epc, 32'h0);
        chk("reset_cause", {30'b0, trap_cause}, 32'h0);
        rst_n = 1;
        #1;
        chk("boot_fv", {31'b0, fetch_valid}, 32'h0);

        // Free run: BOOT->RUN keeps pc, then +4 per cycle
        step(); chk("run0_pc", pc, 32'h0); chk("run0_fv", {31'b0, fetch_valid}, 32'h1);
        step(); chk("run1_pc", pc, 32'h4);
        step(); chk("run2_pc", pc, 32'h8);
        step(); chk("run3_pc", pc, 32'hC); chk("run3_seq", pc_next_seq, 32'h10);
        step(); chk("run4_pc", pc, 32'h10);

        // Jump and branch together: jump wins
        jump = 1; jump_target = 32'h40; branch_taken = 1; branch_target = 32'h80;
        step(); chk("jmp_pc", pc, 32'h40);
        clear_inputs();
        step(); chk("jmp_next_pc", pc, 32'h44);

        // Misaligned branch traps with cause 2, mret returns
        jump = 1; jump_target = 32'h20;
        step(); chk("to20_pc", pc, 32'h20);
        clear_inputs(); branch_taken = 1; branch_target = 32'h32;
        step();
        chk("mis_pc", pc, 32'h100); chk("mis_epc", epc, 32'h20);
        chk("mis_cause", {30'b0, trap_cause}, 32'h2);
        clear_inputs(); mret = 1;
        step(); chk("mret_pc", pc, 32'h20); chk("mret_cause", {30'b0, trap_cause}, 32'h0);

        // Stall blocks jump; trap overrides stall
        clear_inputs(); jump = 1; jump_target = 32'h30;
        step(); chk("to30_pc", pc, 32'h30);
        stall = 1; jump_target = 32'h60;
        step(); chk("stall1_pc", pc, 32'h30);
        step(); chk("stall2_pc", pc, 32'h30);
        step(); chk("stall3_pc", pc, 32'h30);
        trap = 1;
        step();
        chk("stalltrap_pc", pc, 32'h100); chk("stalltrap_epc", epc, 32'h30);
        chk("stalltrap_cause", {30'b0, trap_cause}, 32'h1);

        // Wrap at top of address space, then HALT/resume
        clear_inputs(); jump = 1; jump_target = 32'hFFFF_FFFC;
        step(); chk("top_pc", pc, 32'hFFFF_FFFC); chk("top_seq", pc_next_seq, 32'h0);
        clear_inputs();
        step(); chk("wrap_pc", pc, 32'h0);
        halt = 1;
        step(); chk("halt_halted", {31'b0, halted}, 32'h1); chk("halt_pc", pc, 32'h0);
        chk("halt_fv", {31'b0, fetch_valid}, 32'h0);
        halt = 0; jump = 1; jump_target = 32'h200; mret = 1;
        step(); chk("halt1_pc", pc, 32'h0);
        step(); chk("halt2_pc", pc, 32'h0);
        chk("halt_cause_sticky", {30'b0, trap_cause}, 32'h1);
        clear_inputs(); resume = 1;
        step(); chk("resume_pc", pc, 32'h0); chk("resume_halted", {31'b0, halted}, 32'h0);
        chk("resume_fv", {31'b0, fetch_valid}, 32'h1);
        resume = 0;
        step(); chk("resume1_pc", pc, 32'h4);
        step(); chk("resume2_pc", pc, 32'h8);

        // Trap from HALT goes to RUN at the trap vector
        halt = 1;
        step(); chk("halt_b", {31'b0, halted}, 32'h1);
        halt = 0; trap = 1;
        step(); chk("halttrap_pc", pc, 32'h100); chk("halttrap_epc", epc, 32'h8);
        chk("halttrap_fv", {31'b0, fetch_valid}, 32'h1);

        // Trap and mret together: trap wins
        clear_inputs(); jump = 1; jump_target = 32'h48;
        step(); chk("to48_pc", pc, 32'h48);
        clear_inputs(); trap = 1; mret = 1;
        step(); chk("tm_pc", pc, 32'h100); chk("tm_epc", epc, 32'h48);
        chk("tm_cause", {30'b0, trap_cause}, 32'h1);

        // Asynchronous reset mid-cycle
        clear_inputs(); jump = 1; jump_target = 32'h48;
        step(); chk("pre_rst_pc", pc, 32'h48);
        #3; rst_n = 0; #1;
        chk("arst_pc", pc, 32'h0); chk("arst_fv", {31'b0, fetch_valid}, 32'h0);
        chk("arst_epc", epc, 32'h0); chk("arst_cause", {30'b0, trap_cause}, 32'h0);
        rst_n = 1;
        step(); chk("reboot_pc", pc, 32'h0); chk("reboot_fv", {31'b0, fetch_valid}, 32'h1);
        clear_inputs();
        step(); chk("reboot1_pc", pc, 32'h4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
